// File: rtl/cell_comm_fa_packetizer.sv
// FA packet transmitter for one cell-controller ring link direction.
// Each FA toggle frames a header plus CHAN_COUNT position words into an
// AXI-stream packet, with sequence numbering, channel-up gating, overrun and
// link-drop accounting, and abort of an in-flight packet when the link drops.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no packet in flight, txValid low, waiting for an FA event
//  HDR   | header word presented on txData, waiting for txReady
//  DATA  | position word wordCnt presented, txLast on the final word
module cell_comm_fa_packetizer #(
  parameter int CHAN_COUNT     = 3,
  parameter int ADC_COUNT      = 4,
  parameter int FOFB_IDX_WIDTH = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             sysClk,
  input  logic                             sysResetN,
  input  logic [CHAN_COUNT*DATA_WIDTH-1:0] sysFaData,
  input  logic                             sysFaToggle,
  input  logic [ADC_COUNT-1:0]             sysClippedAdc,
  input  logic                             sysFOFBvalid,
  input  logic [FOFB_IDX_WIDTH-1:0]        sysFOFBindex,
  input  logic                             sysChannelUp,
  input  logic                             sysCountersClear,
  output logic                             txValid,
  output logic                             txLast,
  output logic [DATA_WIDTH-1:0]            txData,
  input  logic                             txReady,
  output logic [7:0]                       sysSeq,
  output logic [CNT_WIDTH-1:0]             sysOverrunCount,
  output logic [CNT_WIDTH-1:0]             sysLinkDropCount,
  output logic                             sysBusy
);

  localparam int IDX_W = (CHAN_COUNT > 1) ? $clog2(CHAN_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAN_COUNT - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} pktState;

  pktState                 state;
  logic [IDX_W-1:0]        wordCnt;
  logic [IDX_W-1:0]        nextIdx;
  logic [DATA_WIDTH-1:0]   faWords [CHAN_COUNT];
  logic                    toggleHist;

  logic                    faEvent;
  logic                    busy;
  logic                    finalHs;
  logic                    acceptEv;
  logic                    abortPkt;
  logic                    linkDropEv;
  logic                    overrunEv;
  logic [1:0]              linkInc;
  logic [DATA_WIDTH-1:0]   hdrWord;

  // Saturating add of a small increment; the link counter can see an abort
  // and a refused event in the same cycle, hence the 2-bit increment.
  function automatic logic [CNT_WIDTH-1:0] satAdd(input logic [CNT_WIDTH-1:0] cnt,
                                                  input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // Event qualification and header assembly from the live inputs.
  always_comb begin
    faEvent    = (sysFaToggle != toggleHist);
    busy       = (state != IDLE);
    finalHs    = (state == DATA) && txValid && txReady && sysChannelUp &&
                 (wordCnt == LAST_IDX);
    acceptEv   = faEvent && sysFOFBvalid && sysChannelUp && (!busy || finalHs);
    abortPkt   = busy && !sysChannelUp;
    linkDropEv = faEvent && sysFOFBvalid && !sysChannelUp;
    overrunEv  = faEvent && sysFOFBvalid && sysChannelUp && busy && !finalHs;
    linkInc    = {1'b0, linkDropEv} + {1'b0, abortPkt};
    nextIdx    = wordCnt + IDX_W'(1);
    hdrWord    = {4'hA, |sysClippedAdc, 3'b000, sysSeq, 16'(sysFOFBindex)};
  end

  assign sysBusy = busy;

  // Toggle history; reset loads the current level so release makes no event.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      toggleHist <= sysFaToggle;
    end else begin
      toggleHist <= sysFaToggle;
    end
  end

  // Snapshot of the FA words taken when an event is accepted.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      for (int i = 0; i < CHAN_COUNT; i++) faWords[i] <= '0;
    end else if (acceptEv) begin
      for (int i = 0; i < CHAN_COUNT; i++) begin
        faWords[i] <= sysFaData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Packet framing FSM; a link drop overrides any handshake in progress.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      state   <= IDLE;
      wordCnt <= '0;
      txValid <= 1'b0;
      txLast  <= 1'b0;
      txData  <= '0;
      sysSeq  <= '0;
    end else if (abortPkt) begin
      state   <= IDLE;
      wordCnt <= '0;
      txValid <= 1'b0;
      txLast  <= 1'b0;
      txData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acceptEv) begin
            state   <= HDR;
            txValid <= 1'b1;
            txLast  <= 1'b0;
            txData  <= hdrWord;
          end
        end
        HDR: begin
          if (txReady) begin
            state   <= DATA;
            wordCnt <= '0;
            txData  <= faWords[0];
            txLast  <= (LAST_IDX == '0);
            sysSeq  <= sysSeq + 8'd1;
          end
        end
        DATA: begin
          if (txReady) begin
            if (wordCnt == LAST_IDX) begin
              wordCnt <= '0;
              if (acceptEv) begin
                // Back-to-back: next header follows without an idle cycle.
                state   <= HDR;
                txValid <= 1'b1;
                txLast  <= 1'b0;
                txData  <= hdrWord;
              end else begin
                state   <= IDLE;
                txValid <= 1'b0;
                txLast  <= 1'b0;
                txData  <= '0;
              end
            end else begin
              wordCnt <= nextIdx;
              txData  <= faWords[nextIdx];
              txLast  <= (nextIdx == LAST_IDX);
            end
          end
        end
        default: begin
          state   <= IDLE;
          txValid <= 1'b0;
          txLast  <= 1'b0;
        end
      endcase
    end
  end

  // Drop accounting; a clear pulse wins over a same-cycle increment.
  always_ff @(posedge sysClk or negedge sysResetN) begin
    if (!sysResetN) begin
      sysOverrunCount  <= '0;
      sysLinkDropCount <= '0;
    end else if (sysCountersClear) begin
      sysOverrunCount  <= '0;
      sysLinkDropCount <= '0;
    end else begin
      sysOverrunCount  <= satAdd(sysOverrunCount, {1'b0, overrunEv});
      sysLinkDropCount <= satAdd(sysLinkDropCount, linkInc);
    end
  end

endmodule

// File: tb/tb_cell_comm_fa_packetizer.sv
module tb_cell_comm_fa_packetizer;

  localparam int CH  = 3;
  localparam int ADC = 4;
  localparam int IW  = 9;
  localparam int DW  = 32;
  localparam int CW  = 8;

  logic              sysClk = 1'b0;
  logic              sysResetN = 1'b0;
  logic [CH*DW-1:0]  sysFaData = '0;
  logic              sysFaToggle = 1'b0;
  logic [ADC-1:0]    sysClippedAdc = '0;
  logic              sysFOFBvalid = 1'b1;
  logic [IW-1:0]     sysFOFBindex = '0;
  logic              sysChannelUp = 1'b1;
  logic              sysCountersClear = 1'b0;
  logic              txValid;
  logic              txLast;
  logic [DW-1:0]     txData;
  logic              txReady = 1'b1;
  logic [7:0]        sysSeq;
  logic [CW-1:0]     sysOverrunCount;
  logic [CW-1:0]     sysLinkDropCount;
  logic              sysBusy;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  expSeq = 8'd0;
  logic [32:0] expQ[$];
  logic [32:0] monExp;
  logic        holdPend = 1'b0;
  logic [31:0] holdData = '0;
  logic        holdLast = 1'b0;

  cell_comm_fa_packetizer #(
    .CHAN_COUNT(CH), .ADC_COUNT(ADC), .FOFB_IDX_WIDTH(IW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .sysClk(sysClk), .sysResetN(sysResetN), .sysFaData(sysFaData),
    .sysFaToggle(sysFaToggle), .sysClippedAdc(sysClippedAdc),
    .sysFOFBvalid(sysFOFBvalid), .sysFOFBindex(sysFOFBindex),
    .sysChannelUp(sysChannelUp), .sysCountersClear(sysCountersClear),
    .txValid(txValid), .txLast(txLast), .txData(txData), .txReady(txReady),
    .sysSeq(sysSeq), .sysOverrunCount(sysOverrunCount),
    .sysLinkDropCount(sysLinkDropCount), .sysBusy(sysBusy)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Scoreboard monitor and hold-stability checker, sampled mid-cycle.
  always @(negedge sysClk) begin
    if (!sysResetN || !sysChannelUp) begin
      holdPend = 1'b0;
    end else begin
      if (holdPend) begin
        total++;
        if (txValid !== 1'b1 || txData !== holdData || txLast !== holdLast) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   txValid, txData, txLast, holdData, holdLast);
        end
      end
      if (txValid === 1'b1 && txReady === 1'b1) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: data=%h last=%b, required no word", txData, txLast);
        end else begin
          monExp = expQ.pop_front();
          if ({txLast, txData} !== monExp) begin
            bad++;
            $display("FAIL word: last=%b data=%h, required last=%b data=%h",
                     txLast, txData, monExp[32], monExp[31:0]);
          end
        end
      end
      holdPend = (txValid === 1'b1) && (txReady === 1'b0);
      holdData = txData;
      holdLast = txLast;
    end
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic sendPacket(input logic [CH*DW-1:0] data, input logic [ADC-1:0] clip,
                            input logic [IW-1:0] idx);
    logic [31:0] hdr;
    sysFaData     = data;
    sysClippedAdc = clip;
    sysFOFBindex  = idx;
    hdr = {4'hA, |clip, 3'b000, expSeq, 16'(idx)};
    expQ.push_back({1'b0, hdr});
    for (int i = 0; i < CH; i++) expQ.push_back({(i == CH - 1), data[i*DW +: DW]});
    expSeq = expSeq + 8'd1;
    sysFaToggle = ~sysFaToggle;
  endtask

  task automatic waitIdle(input int maxCyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      if (expQ.size() == 0 && sysBusy === 1'b0 && txValid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clearCounters();
    sysCountersClear = 1'b1;
    tick();
    sysCountersClear = 1'b0;
  endtask

  task automatic test_reset();
    sysResetN = 1'b0;
    tick();
    tick();
    sysFaToggle = 1'b1;
    tick();
    total++;
    if ({txValid, txLast, txData, sysSeq, sysOverrunCount, sysLinkDropCount, sysBusy} !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b last=%b data=%h seq=%0d ovr=%0d drop=%0d busy=%b, required all zero",
               txValid, txLast, txData, sysSeq, sysOverrunCount, sysLinkDropCount, sysBusy);
    end
    sysResetN = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (txValid !== 1'b0 || sysBusy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_spurious: valid=%b busy=%b, required 0 0", txValid, sysBusy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    txReady = 1'b1;
    sendPacket({32'd3, 32'd2, 32'd1}, 4'b0000, 9'd5);
    tick();
    sysFaData = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
    total++;
    if (txValid !== 1'b1 || txData !== 32'hA000_0005 || sysSeq !== 8'd0) begin
      bad++;
      $display("FAIL basic_latency: valid=%b data=%h seq=%0d, required 1 a0000005 0",
               txValid, txData, sysSeq);
    end
    waitIdle(20, ok);
    total++;
    if (!ok || sysSeq !== 8'd1) begin
      bad++;
      $display("FAIL basic_done: idle=%b seq=%0d, required 1 1", ok, sysSeq);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    sendPacket({32'h3333_0000, 32'h2222_0000, 32'h1111_0000}, 4'b0100, 9'h1FF);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (expQ.size() == 0 && !sysBusy) begin ok = 1'b1; break; end
      txReady = ~txReady;
      tick();
    end
    total++;
    if (!ok || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL alt_ready_done: idle=%b seq=%0d, required 1 %0d", ok, sysSeq, expSeq);
    end
    sendPacket({$urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), IW'($urandom));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (expQ.size() == 0 && !sysBusy) begin ok = 1'b1; break; end
      txReady = 1'($urandom_range(0, 1));
      tick();
    end
    txReady = 1'b1;
    total++;
    if (!ok || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL rand_ready_done: idle=%b seq=%0d, required 1 %0d", ok, sysSeq, expSeq);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clearCounters();
    total++;
    if (sysOverrunCount !== '0 || sysLinkDropCount !== '0) begin
      bad++;
      $display("FAIL clear: ovr=%0d drop=%0d, required 0 0", sysOverrunCount, sysLinkDropCount);
    end
    txReady = 1'b1;
    sendPacket({32'hC3, 32'hC2, 32'hC1}, 4'b0001, 9'd77);
    tick();
    tick();
    txReady = 1'b0;
    tick();
    sysFaData = {32'hEE, 32'hEE, 32'hEE};
    sysFaToggle = ~sysFaToggle;
    tick();
    total++;
    if (sysOverrunCount !== 8'd1 || sysBusy !== 1'b1) begin
      bad++;
      $display("FAIL overrun_count: ovr=%0d busy=%b, required 1 1", sysOverrunCount, sysBusy);
    end
    txReady = 1'b1;
    waitIdle(20, ok);
    tick();
    tick();
    total++;
    if (!ok || txValid !== 1'b0 || sysOverrunCount !== 8'd1 || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL overrun_after: idle=%b valid=%b ovr=%0d seq=%0d, required 1 0 1 %0d",
               ok, txValid, sysOverrunCount, sysSeq, expSeq);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] hdr2;
    clearCounters();
    txReady = 1'b1;
    sendPacket({32'hA3, 32'hA2, 32'hA1}, 4'b0000, 9'd10);
    tick();
    tick();
    tick();
    tick();
    hdr2 = {4'hA, 1'b1, 3'b000, expSeq, 16'd11};
    sendPacket({32'hB3, 32'hB2, 32'hB1}, 4'b1000, 9'd11);
    tick();
    total++;
    if (txValid !== 1'b1 || txData !== hdr2 || txLast !== 1'b0) begin
      bad++;
      $display("FAIL b2b_header: valid=%b data=%h last=%b, required 1 %h 0",
               txValid, txData, txLast, hdr2);
    end
    waitIdle(20, ok);
    total++;
    if (!ok || sysOverrunCount !== 8'd0 || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL b2b_done: idle=%b ovr=%0d seq=%0d, required 1 0 %0d",
               ok, sysOverrunCount, sysSeq, expSeq);
    end
  endtask

  task automatic test_link_drop();
    clearCounters();
    sysChannelUp = 1'b0;
    sysFaToggle = ~sysFaToggle;
    tick();
    tick();
    tick();
    total++;
    if (txValid !== 1'b0 || sysLinkDropCount !== 8'd1 || sysBusy !== 1'b0 || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL drop_at_event: valid=%b drop=%0d busy=%b seq=%0d, required 0 1 0 %0d",
               txValid, sysLinkDropCount, sysBusy, sysSeq, expSeq);
    end
    sysChannelUp = 1'b1;
    tick();
    sysFOFBvalid = 1'b0;
    sysFaToggle = ~sysFaToggle;
    tick();
    tick();
    tick();
    total++;
    if (txValid !== 1'b0 || sysLinkDropCount !== 8'd1 || sysOverrunCount !== 8'd0) begin
      bad++;
      $display("FAIL fofb_invalid: valid=%b drop=%0d ovr=%0d, required 0 1 0",
               txValid, sysLinkDropCount, sysOverrunCount);
    end
    sysFOFBvalid = 1'b1;
    txReady = 1'b1;
    sysFaData = {32'hD3, 32'hD2, 32'hD1};
    sysClippedAdc = 4'b0000;
    sysFOFBindex = 9'd3;
    expQ.push_back({1'b0, 4'hA, 1'b0, 3'b000, expSeq, 16'd3});
    expSeq = expSeq + 8'd1;
    sysFaToggle = ~sysFaToggle;
    tick();
    tick();
    sysChannelUp = 1'b0;
    tick();
    total++;
    if (txValid !== 1'b0 || txLast !== 1'b0 || sysLinkDropCount !== 8'd2 ||
        sysBusy !== 1'b0 || sysSeq !== expSeq || expQ.size() != 0) begin
      bad++;
      $display("FAIL abort_data: valid=%b last=%b drop=%0d busy=%b seq=%0d pend=%0d, required 0 0 2 0 %0d 0",
               txValid, txLast, sysLinkDropCount, sysBusy, sysSeq, expQ.size(), expSeq);
    end
    sysChannelUp = 1'b1;
    tick();
    txReady = 1'b0;
    sysFaToggle = ~sysFaToggle;
    tick();
    total++;
    if (txValid !== 1'b1) begin
      bad++;
      $display("FAIL abort_hdr_start: valid=%b, required 1", txValid);
    end
    sysChannelUp = 1'b0;
    tick();
    total++;
    if (txValid !== 1'b0 || sysLinkDropCount !== 8'd3 || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL abort_hdr: valid=%b drop=%0d seq=%0d, required 0 3 %0d",
               txValid, sysLinkDropCount, sysSeq, expSeq);
    end
    sysChannelUp = 1'b1;
    txReady = 1'b1;
    tick();
  endtask

  task automatic test_seq_wrap();
    bit ok;
    sysResetN = 1'b0;
    tick();
    sysResetN = 1'b1;
    expQ.delete();
    expSeq = 8'd0;
    tick();
    txReady = 1'b1;
    for (int p = 0; p < 256; p++) begin
      sendPacket({$urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)), IW'($urandom));
      waitIdle(20, ok);
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL wrap_packet: packet %0d did not complete, required completion", p);
        break;
      end
      if (p == 254) begin
        total++;
        if (sysSeq !== 8'd255) begin
          bad++;
          $display("FAIL wrap_255: seq=%0d, required 255", sysSeq);
        end
      end
    end
    total++;
    if (sysSeq !== 8'd0) begin
      bad++;
      $display("FAIL wrap_zero: seq=%0d, required 0", sysSeq);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    clearCounters();
    txReady = 1'b0;
    sendPacket({32'hF3, 32'hF2, 32'hF1}, 4'b0010, 9'd100);
    tick();
    for (int i = 0; i < 300; i++) begin
      sysFaToggle = ~sysFaToggle;
      tick();
    end
    total++;
    if (sysOverrunCount !== 8'hFF) begin
      bad++;
      $display("FAIL overrun_sat: ovr=%0d, required 255", sysOverrunCount);
    end
    sysFaToggle = ~sysFaToggle;
    sysCountersClear = 1'b1;
    tick();
    sysCountersClear = 1'b0;
    total++;
    if (sysOverrunCount !== 8'd0) begin
      bad++;
      $display("FAIL overrun_clear_prio: ovr=%0d, required 0", sysOverrunCount);
    end
    sysFaToggle = ~sysFaToggle;
    tick();
    total++;
    if (sysOverrunCount !== 8'd1) begin
      bad++;
      $display("FAIL overrun_after_clear: ovr=%0d, required 1", sysOverrunCount);
    end
    txReady = 1'b1;
    waitIdle(20, ok);
    total++;
    if (!ok || sysSeq !== expSeq) begin
      bad++;
      $display("FAIL sat_packet: idle=%b seq=%0d, required 1 %0d", ok, sysSeq, expSeq);
    end
    sysChannelUp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      sysFaToggle = ~sysFaToggle;
      tick();
    end
    total++;
    if (sysLinkDropCount !== 8'hFF) begin
      bad++;
      $display("FAIL drop_sat: drop=%0d, required 255", sysLinkDropCount);
    end
    sysFaToggle = ~sysFaToggle;
    sysCountersClear = 1'b1;
    tick();
    sysCountersClear = 1'b0;
    total++;
    if (sysLinkDropCount !== 8'd0) begin
      bad++;
      $display("FAIL drop_clear_prio: drop=%0d, required 0", sysLinkDropCount);
    end
    sysChannelUp = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_link_drop();
    test_seq_wrap();
    test_saturation();
    tick();
    tick();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL leftover_words: pending=%0d, required 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
